// File: rtl/ps2_key_sequencer_pkg.sv
// Shared constants and types for the PS/2 set-2 key sequencer: scan-code
// prefixes, control bytes, parser state encoding and the {ext,code} key id.
package ps2_key_sequencer_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_RSND = 8'hFE;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_id_t;

  // Keyboard housekeeping bytes that never describe a key action.
  function automatic logic is_ctrl_code(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RSND) ||
           (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

  function automatic key_id_t mk_key_id(input logic ext, input logic [7:0] code);
    key_id_t k;
    k.ext  = ext;
    k.code = code;
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-FIFO pop handshake from ps2_keyboard plus the valid/ready key-event
// port. master = the sequencer, slave = keyboard FIFO / event consumer side.
interface ps2_key_sequencer_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    input  kb_data,
    input  kb_ready,
    input  kb_overflow,
    output kb_nextdata_n,
    output evt_valid,
    input  evt_ready,
    output evt_code,
    output evt_ext,
    output evt_break
  );

  modport slave (
    output kb_data,
    output kb_ready,
    output kb_overflow,
    input  kb_nextdata_n,
    input  evt_valid,
    output evt_ready,
    input  evt_code,
    input  evt_ext,
    input  evt_break
  );
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan-code parser: pops the keyboard FIFO, folds E0/F0 prefixes
// and emits one make/break event per key action. Define TYPEMATIC_FILTER_EN
// to drop auto-repeat makes of the currently held key.
//
// state  | meaning
// IDLE   | wait for a FIFO byte, capture head into byte_r
// POP    | kb_nextdata_n low for one cycle
// DECODE | classify byte_r: prefix, control byte, or key code
// EMIT   | event presented, held until evt_ready
module ps2_key_sequencer
  import ps2_key_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_key_sequencer_if.master  bus,
  output logic                 key_held,
  output logic [8:0]           held_code,
  output logic [CNT_W-1:0]     press_count,
  output logic                 ovf_sticky
);

  seq_state_t       state_q, state_d;
  logic [7:0]       byte_r;
  logic             ext_pend, brk_pend;
  logic             ext_pend_d, brk_pend_d;
  logic             capture, load_evt, pop_n;
  logic             repeat_hit, accept;

  logic [7:0]       evt_code_q;
  logic             evt_ext_q, evt_brk_q;
  logic             key_held_q;
  key_id_t          held_id_q;
  key_id_t          evt_id;
  logic [CNT_W-1:0] press_count_q;
  logic             ovf_q;

`ifdef TYPEMATIC_FILTER_EN
  assign repeat_hit = !brk_pend && key_held_q &&
                      (mk_key_id(ext_pend, byte_r) == held_id_q);
`else
  assign repeat_hit = 1'b0;
`endif

  assign accept = (state_q == ST_EMIT) && bus.evt_ready;
  assign evt_id = mk_key_id(evt_ext_q, evt_code_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      state_q  <= state_d;
      ext_pend <= ext_pend_d;
      brk_pend <= brk_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ext_pend_d = ext_pend;
    brk_pend_d = brk_pend;
    capture    = 1'b0;
    load_evt   = 1'b0;
    pop_n      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.kb_ready) begin
          capture = 1'b1;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        pop_n   = 1'b0;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_r == SC_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_r == SC_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          // Any non-prefix byte terminates the sequence, emitted or not.
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (!is_ctrl_code(byte_r) && !repeat_hit) begin
            load_evt = 1'b1;
            state_d  = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (bus.evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r <= 8'h00;
    end else if (capture) begin
      byte_r <= bus.kb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_code_q <= 8'h00;
      evt_ext_q  <= 1'b0;
      evt_brk_q  <= 1'b0;
    end else if (load_evt) begin
      evt_code_q <= byte_r;
      evt_ext_q  <= ext_pend;
      evt_brk_q  <= brk_pend;
    end
  end

  // Held-key tracking only follows events the consumer actually took.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_held_q    <= 1'b0;
      held_id_q     <= '0;
      press_count_q <= '0;
    end else if (accept) begin
      if (!evt_brk_q) begin
        key_held_q    <= 1'b1;
        held_id_q     <= evt_id;
        press_count_q <= press_count_q + CNT_W'(1);
      end else if (evt_id == held_id_q) begin
        key_held_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.kb_overflow) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.kb_nextdata_n = pop_n;
  assign bus.evt_valid     = (state_q == ST_EMIT);
  assign bus.evt_code      = evt_code_q;
  assign bus.evt_ext       = evt_ext_q;
  assign bus.evt_break     = evt_brk_q;

  assign key_held    = key_held_q;
  assign held_code   = held_id_q;
  assign press_count = press_count_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench: keyboard FIFO model plus a scan-code level reference
// model of the event stream, held key, press count and overflow flag.
module tb_ps2_key_sequencer;

  logic clk;
  logic rst;
  logic key_held;
  logic [8:0] held_code;
  logic [7:0] press_count;
  logic ovf_sticky;

  ps2_key_sequencer_if bus();

  ps2_key_sequencer #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .key_held    (key_held),
    .held_code   (held_code),
    .press_count (press_count),
    .ovf_sticky  (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    int         due;
  } exp_evt_t;

  exp_evt_t   evq[$];
  logic [7:0] fifo[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // reference model state
  logic       m_ext, m_brk, m_held, m_ovf;
  logic [8:0] m_hc;
  logic [7:0] m_cnt;

  // stimulus controls
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic rst_req = 1'b1;
  logic rst_on_pop = 1'b0;
  logic ovf_req = 1'b0;
  logic prev_pop_low = 1'b0;

  // per-test observation
  int         n_pops, n_events;
  logic [7:0] last_code;
  logic       last_ext, last_brk;
  logic [8:0] held_seen;

  logic [7:0] codes [8] = '{8'h15, 8'h1C, 8'h1D, 8'h24, 8'h2A, 8'h75, 8'h6B, 8'h5A};
  logic [7:0] ctrls [5] = '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_ovf = 1'b0;
    m_hc = 9'h000; m_cnt = 8'h00;
    evq.delete();
    fifo.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic filt;
    exp_evt_t e;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      filt = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      filt = !m_brk && m_held && ({m_ext, b} == m_hc);
`endif
      if (!filt) begin
        e.ext = m_ext; e.brk = m_brk; e.code = b; e.due = cyc + 2;
        evq.push_back(e);
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // One cycle: compare at the falling edge, then drive inputs for the next rise.
  task automatic step();
    logic exp_valid;
    exp_evt_t e;
    @(negedge clk);
    cyc++;
    exp_valid = (evq.size() > 0) && (cyc >= evq[0].due);
    check("evt_valid", bus.evt_valid, exp_valid);
    if (exp_valid && bus.evt_valid === 1'b1) begin
      check("evt_code", bus.evt_code, evq[0].code);
      check("evt_ext", bus.evt_ext, evq[0].ext);
      check("evt_break", bus.evt_break, evq[0].brk);
    end
    check("key_held", key_held, m_held);
    check("held_code", held_code, m_hc);
    check("press_count", press_count, m_cnt);
    check("ovf_sticky", ovf_sticky, m_ovf);
    if (bus.evt_valid === 1'b1) check("no_pop_in_emit", bus.kb_nextdata_n, 1);
    if (bus.kb_nextdata_n === 1'b0) begin
      check("pop_single_cycle", prev_pop_low, 0);
      check("pop_fifo_nonempty", fifo.size() > 0, 1);
    end
    prev_pop_low = (bus.kb_nextdata_n === 1'b0);
    if (key_held === 1'b1) held_seen = held_code;

    rst = rst_req || (rst_on_pop && bus.kb_nextdata_n === 1'b0);
    if (rst) rst_on_pop = 1'b0;
    case (ready_mode)
      0: bus.evt_ready = 1'b1;
      1: bus.evt_ready = ($urandom_range(0, 3) != 0);
      default: bus.evt_ready = 1'b0;
    endcase
    bus.kb_overflow = ovf_req;

    if (rst) begin
      model_reset();
    end else begin
      if (bus.kb_nextdata_n === 1'b0 && fifo.size() > 0) begin
        n_pops++;
        model_byte(fifo.pop_front());
      end
      if (bus.evt_valid === 1'b1 && bus.evt_ready && evq.size() > 0) begin
        e = evq.pop_front();
        n_events++;
        last_code = e.code; last_ext = e.ext; last_brk = e.brk;
        if (!e.brk) begin
          m_cnt++;
          m_held = 1'b1;
          m_hc = {e.ext, e.code};
        end else if ({e.ext, e.code} == m_hc) begin
          m_held = 1'b0;
        end
      end
      if (ovf_req) m_ovf = 1'b1;
    end
    bus.kb_ready = (fifo.size() > 0);
    bus.kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    n_pops = 0; n_events = 0; held_seen = 9'h000;
    last_code = 8'h00; last_ext = 1'b0; last_brk = 1'b0;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;
    run(1);
    clear_obs();
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'hE0;
    if (r < 35) return 8'hF0;
    if (r < 40) return ctrls[$urandom_range(0, 4)];
    return codes[$urandom_range(0, 7)];
  endfunction

  initial begin
    rst = 1'b1;
    bus.kb_data = 8'h00;
    bus.kb_ready = 1'b0;
    bus.kb_overflow = 1'b0;
    bus.evt_ready = 1'b1;
    model_reset();
    clear_obs();

    // reset state
    run(1);
    check("rst_nextdata_n", bus.kb_nextdata_n, 1);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_press_count", press_count, 0);
    do_reset();

    // single make
    fifo.push_back(8'h15);
    run(15);
    check("t1_events", n_events, 1);
    check("t1_code", last_code, 8'h15);
    check("t1_ext_brk", {last_ext, last_brk}, 2'b00);
    check("t1_count", press_count, 1);
    check("t1_held_code", held_code, 9'h015);
    check("t1_pops", n_pops, 1);

    // make then break
    do_reset();
    fifo = '{8'h15, 8'hF0, 8'h15};
    run(25);
    check("t2_events", n_events, 2);
    check("t2_last_brk", last_brk, 1);
    check("t2_key_held", key_held, 0);
    check("t2_pops", n_pops, 3);
    check("t2_count", press_count, 1);

    // extended make / extended break
    do_reset();
    fifo = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    run(30);
    check("t3_events", n_events, 2);
    check("t3_held_seen", held_seen, 9'h175);
    check("t3_last", {last_ext, last_brk, last_code}, {2'b11, 8'h75});
    check("t3_key_held", key_held, 0);
    check("t3_count", press_count, 1);

    // backpressure
    do_reset();
    ready_mode = 2;
    fifo = '{8'h16, 8'h1E};
    run(20);
    check("t4_valid_held", bus.evt_valid, 1);
    check("t4_pops_stalled", n_pops, 1);
    check("t4_kb_ready", bus.kb_ready, 1);
    ready_mode = 0;
    run(20);
    check("t4_events", n_events, 2);
    check("t4_last_code", last_code, 8'h1E);
    check("t4_pops", n_pops, 2);
    check("t4_count", press_count, 2);

    // auto-repeat
    do_reset();
    fifo = '{8'h1C, 8'h1C, 8'h1C};
    run(30);
`ifdef TYPEMATIC_FILTER_EN
    check("t5_events", n_events, 1);
    check("t5_count", press_count, 1);
`else
    check("t5_events", n_events, 3);
    check("t5_count", press_count, 3);
`endif
    check("t5_pops", n_pops, 3);

    // reset while EMIT is pending
    do_reset();
    fifo.push_back(8'h16);
    run(12);
    ready_mode = 2;
    fifo.push_back(8'h2A);
    begin
      int k = 0;
      while (bus.evt_valid !== 1'b1 && k < 20) begin step(); k++; end
    end
    check("t6_reach_emit", bus.evt_valid, 1);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    ready_mode = 0;
    run(1);
    check("t6_emit_rst_valid", bus.evt_valid, 0);
    check("t6_emit_rst_count", press_count, 0);
    check("t6_emit_rst_held", key_held, 0);

    // reset during the pop cycle
    clear_obs();
    fifo.push_back(8'h16);
    run(12);
    check("t6_pre_pop_count", press_count, 1);
    rst_on_pop = 1'b1;
    fifo.push_back(8'h2B);
    begin
      int k = 0;
      while (rst_on_pop && k < 20) begin step(); k++; end
    end
    check("t6_pop_rst_hit", rst_on_pop, 0);
    rst_req = 1'b0;
    run(1);
    check("t6_pop_rst_nextdata", bus.kb_nextdata_n, 1);
    check("t6_pop_rst_count", press_count, 0);
    check("t6_pop_rst_held_code", held_code, 0);

    // control bytes and overflow
    do_reset();
    fifo = '{8'h00, 8'hAA};
    run(15);
    check("t6_ctrl_events", n_events, 0);
    check("t6_ctrl_pops", n_pops, 2);
    check("t6_ovf_before", ovf_sticky, 0);
    ovf_req = 1'b1;
    run(1);
    ovf_req = 1'b0;
    run(5);
    check("t6_ovf_sticky", ovf_sticky, 1);

    // randomized traffic
    ready_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (fifo.size() < 3 && $urandom_range(0, 2) == 0) fifo.push_back(rand_byte());
      ovf_req = ($urandom_range(0, 999) == 0);
      rst_req = ($urandom_range(0, 799) == 0);
      step();
    end
    ovf_req = 1'b0;
    rst_req = 1'b0;
    ready_mode = 0;
    run(60);
    check("drain_fifo_empty", bus.kb_ready, 0);
    check("drain_no_event", bus.evt_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
